// File: rtl/ib_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ib_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int DEF_AWIDTH = 6;
    localparam int DEF_DWIDTH = 32;

    // The opcode occupies the top OP_WIDTH bits of every instruction word.
    localparam int OP_WIDTH = 6;
    localparam logic [OP_WIDTH-1:0] DEF_HALT_OP = 6'h3F;

endpackage

// File: rtl/ib_pc_incr.sv
// Next-PC adder; the sum wraps modulo 2^AWIDTH with no carry out.
module ib_pc_incr #(
    parameter int AWIDTH = 6
) (
    input  logic [AWIDTH-1:0] pc,
    input  logic [AWIDTH-1:0] inc,
    output logic [AWIDTH-1:0] sum
);

    assign sum = pc + inc;

endmodule

// File: rtl/ib_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake
// and holds each fetched word until decode accepts it.
module ib_fetch_ctrl
    import ib_pkg::*;
#(
    parameter int                  AWIDTH   = DEF_AWIDTH,
    parameter int                  DWIDTH   = DEF_DWIDTH,
    parameter logic [AWIDTH-1:0]   RESET_PC = '0,
    parameter logic [OP_WIDTH-1:0] HALT_OP  = DEF_HALT_OP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_addr,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy,
    output logic              halted
);

    localparam int OP_LSB = DWIDTH - OP_WIDTH;

    fetch_state_t      state, state_next;
    logic [AWIDTH-1:0] pc, pc_next, pc_plus1;
    logic              load_instr;

    ib_pc_incr #(.AWIDTH(AWIDTH)) u_pc_incr (
        .pc  (pc),
        .inc (AWIDTH'(1)),
        .sum (pc_plus1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (load_instr) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

    // Redirect has priority over ack and over halt detection in every busy state.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load_instr = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (redirect) pc_next = redirect_addr;
                if (start)    state_next = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_next = redirect_addr;
                end else if (imem_ack) begin
                    load_instr = 1'b1;
                    pc_next    = pc_plus1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_addr;
                    state_next = FETCH;
                end else if (instr_ready) begin
                    if (instr[DWIDTH-1:OP_LSB] == HALT_OP) state_next = HALT;
                    else                                   state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign busy        = (state == FETCH) || (state == HOLD);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_ib_fetch_ctrl.sv
// Directed vector bench for ib_fetch_ctrl: a per-cycle stimulus table plus
// hand-written sequences for async reset and IDLE-state redirects.
module tb_ib_fetch_ctrl;

    localparam logic [31:0] HALT_W3  = 32'hFC00_0003;
    localparam logic [31:0] HALT_W20 = 32'hFC00_0014;

    typedef struct {
        logic        start;
        logic        redirect;
        logic [5:0]  raddr;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [5:0]  e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [5:0]  e_ipc;
        logic        e_busy;
        logic        e_halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [5:0]  redirect_addr = '0;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_ready = 1'b0;
    logic        busy;
    logic        halted;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    ib_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .busy          (busy),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic rd, input logic [5:0] ra,
                                input logic ak, input logic [31:0] rdt, input logic rdy,
                                input logic req, input logic [5:0] addr, input logic vld,
                                input logic [31:0] ins, input logic [5:0] ipc,
                                input logic bsy, input logic hlt);
        vec_t v;
        v.start = st;   v.redirect = rd;  v.raddr = ra;
        v.ack = ak;     v.rdata = rdt;    v.ready = rdy;
        v.e_req = req;  v.e_addr = addr;  v.e_valid = vld;
        v.e_instr = ins; v.e_ipc = ipc;   v.e_busy = bsy;
        v.e_halted = hlt;
        return v;
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the clock edge pass, then sample #1 later.
    task automatic applyStimulus(input vec_t v);
        start         = v.start;
        redirect      = v.redirect;
        redirect_addr = v.raddr;
        imem_ack      = v.ack;
        imem_rdata    = v.rdata;
        instr_ready   = v.ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        compareField({tag, ".imem_req"},    32'(imem_req),    32'(v.e_req));
        compareField({tag, ".imem_addr"},   32'(imem_addr),   32'(v.e_addr));
        compareField({tag, ".instr_valid"}, 32'(instr_valid), 32'(v.e_valid));
        compareField({tag, ".instr"},       instr,            v.e_instr);
        compareField({tag, ".instr_pc"},    32'(instr_pc),    32'(v.e_ipc));
        compareField({tag, ".busy"},        32'(busy),        32'(v.e_busy));
        compareField({tag, ".halted"},      32'(halted),      32'(v.e_halted));
    endtask

    initial begin
        // start, redirect, raddr, ack, rdata, ready | req, addr, valid, instr, ipc, busy, halted
        vecs.push_back(mk(1,0, 0,0,0,       0, 1, 0,0,0,       0, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       0, 1, 0,0,0,       0, 1,0));
        vecs.push_back(mk(0,0, 0,1,0,       0, 0, 1,1,0,       0, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 1, 1,0,0,       0, 1,0));
        vecs.push_back(mk(0,0, 0,1,1,       0, 0, 2,1,1,       1, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 1, 2,0,1,       1, 1,0));
        vecs.push_back(mk(0,0, 0,1,2,       0, 0, 3,1,2,       2, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 1, 3,0,2,       2, 1,0));
        vecs.push_back(mk(0,0, 0,1,HALT_W3, 0, 0, 4,1,HALT_W3, 3, 1,0));
        // backpressure: held word stays put, start and stray ack are ignored
        vecs.push_back(mk(0,0, 0,0,0,       0, 0, 4,1,HALT_W3, 3, 1,0));
        vecs.push_back(mk(1,0, 0,1,32'h99,  0, 0, 4,1,HALT_W3, 3, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       0, 0, 4,1,HALT_W3, 3, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       0, 0, 4,1,HALT_W3, 3, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       0, 0, 4,1,HALT_W3, 3, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 0, 4,0,HALT_W3, 3, 0,1));
        vecs.push_back(mk(0,0, 0,1,32'hDEAD,0, 0, 4,0,HALT_W3, 3, 0,1));
        vecs.push_back(mk(1,0, 0,0,0,       0, 1, 4,0,HALT_W3, 3, 1,0));
        vecs.push_back(mk(0,0, 0,1,4,       0, 0, 5,1,4,       4, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 1, 5,0,4,       4, 1,0));
        // redirect beats ack in FETCH
        vecs.push_back(mk(0,1,20,1,5,       0, 1,20,0,4,       4, 1,0));
        vecs.push_back(mk(0,0, 0,1,HALT_W20,0, 0,21,1,HALT_W20,20, 1,0));
        // redirect with ready on a halt opcode: no halt
        vecs.push_back(mk(0,1,62,0,0,       1, 1,62,0,HALT_W20,20, 1,0));
        vecs.push_back(mk(0,0, 0,1,62,      0, 0,63,1,62,     62, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 1,63,0,62,     62, 1,0));
        vecs.push_back(mk(0,0, 0,1,63,      0, 0, 0,1,63,     63, 1,0));
        vecs.push_back(mk(0,0, 0,0,0,       1, 1, 0,0,63,     63, 1,0));
        vecs.push_back(mk(0,0, 0,1,0,       0, 0, 1,1,0,       0, 1,0));
        vecs.push_back(mk(0,1,10,0,0,       0, 1,10,0,0,       0, 1,0));

        #2;
        checkOutput(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0), "reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset while FETCH at pc=10 is outstanding.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0), "async_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(0,0,0,1,32'h55,0, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0), "late_ack");

        // IDLE redirect presets the entry point without fetching.
        applyStimulus(mk(0,1,63,0,0,0, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 0,63,0,0,0,0,0), "idle_redir");
        applyStimulus(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 1,63,0,0,0,1,0), "wrap_fetch63");
        applyStimulus(mk(0,0,0,1,32'h77,0, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 0,0,1,32'h77,63,1,0), "wrap_hold63");
        applyStimulus(mk(0,0,0,0,0,1, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 1,0,0,32'h77,63,1,0), "wrap_fetch0");
        applyStimulus(mk(0,0,0,1,32'h10,0, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 0,1,1,32'h10,0,1,0), "wrap_hold0");

        // Start and redirect together in IDLE: load and fetch.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk(1,1,7,0,0,0, 0,0,0,0,0,0,0));
        checkOutput(mk(0,0,0,0,0,0, 1,7,0,0,0,1,0), "start_redir");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
